dmac_ahb_regif_mc: RTL and testbench

//  Multi-channel AHB-Lite slave register interface for the DMAC, with the register bank built in.

---
 rtl/dmac_pkg.sv | 48 ++++
 rtl/dmac_ch_regs.sv | 83 ++++++++
 rtl/dmac_ahb_regif_mc.sv | 183 ++++++++++++++++++
 tb/tb_dmac_ahb_regif_mc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared encodings for the DMAC AHB register interface: response codes, register map, FSM states.
// Latency: none (constants and types only).
// Backpressure: none.
package dmac_pkg;

  // AHB-Lite response encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Global register byte addresses
  localparam int unsigned GLB_CFG_ADDR  = 'h030;
  localparam int unsigned INT_STAT_ADDR = 'h034;

  // Channel windows start at CH_BASE_ADDR, one 0x20-byte window per channel
  localparam int unsigned CH_BASE_ADDR   = 'h100;
  localparam int unsigned CH_STRIDE_LOG2 = 5;

  // Offsets inside a channel window
  localparam logic [4:0] OFF_SRC  = 5'h00;
  localparam logic [4:0] OFF_DST  = 5'h04;
  localparam logic [4:0] OFF_CTRL = 5'h0C;
  localparam logic [4:0] OFF_CFG  = 5'h10;

  // Implemented width of the per-channel Control register
  localparam int CTRL_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Decoded view of one bus address, latched in the address phase
  typedef struct packed {
    logic       glb_cfg;
    logic       glb_int;
    logic       ch_hit;
    logic [2:0] ch;
    logic [4:0] off;
  } dec_t;

  function automatic logic off_valid(input logic [4:0] off);
    return (off == OFF_SRC) || (off == OFF_DST) || (off == OFF_CTRL) || (off == OFF_CFG);
  endfunction

endpackage

// File: rtl/dmac_ch_regs.sv
// One DMA channel's register set: SrcAddr, DestAddr, Control and Config (en, mask, W1C pend).
// Latency: writes land on the clock edge ending the data phase; read data is combinational.
// Backpressure: none; the parent FSM only raises wr_en_i in an accepted data phase.
module dmac_ch_regs
  import dmac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [4:0]        offset_i,
  input  logic [31:0]       wdata_i,
  input  logic              ch_done_i,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  output logic [CTRL_W-1:0] control_o,
  output logic              en_o,
  output logic              mask_o,
  output logic              pend_o,
  output logic [31:0]       rdata_o
);

  logic [31:0]       src_q;
  logic [31:0]       dst_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              en_q;
  logic              mask_q;
  logic              pend_q;
  logic              pend_d;
  logic              cfg_wr;

  assign cfg_wr = wr_en_i && (offset_i == OFF_CFG);

  // Pending bit: a done pulse wins over a simultaneous write-1-to-clear
  always_comb begin
    pend_d = (pend_q && !(cfg_wr && wdata_i[2])) || ch_done_i;
  end

  // Register updates from bus writes and engine completion pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      ctrl_q <= '0;
      en_q   <= 1'b0;
      mask_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wr_en_i) begin
        case (offset_i)
          OFF_SRC:  src_q  <= wdata_i;
          OFF_DST:  dst_q  <= wdata_i;
          OFF_CTRL: ctrl_q <= wdata_i[CTRL_W-1:0];
          OFF_CFG: begin
            en_q   <= wdata_i[0];
            mask_q <= wdata_i[1];
          end
          default: ;
        endcase
      end
    end
  end

  // Read view of the addressed register; unimplemented bits read 0
  always_comb begin
    rdata_o = '0;
    case (offset_i)
      OFF_SRC:  rdata_o = src_q;
      OFF_DST:  rdata_o = dst_q;
      OFF_CTRL: rdata_o = 32'(ctrl_q);
      OFF_CFG:  rdata_o = {29'b0, pend_q, mask_q, en_q};
      default:  rdata_o = '0;
    endcase
  end

  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign control_o  = ctrl_q;
  assign en_o       = en_q;
  assign mask_o     = mask_q;
  assign pend_o     = pend_q;

endmodule

// File: rtl/dmac_ahb_regif_mc.sv
// AHB-Lite slave register interface for a multi-channel DMAC: decode, global regs, channel banks, irq.
// Latency: OKAY data phase after WAIT_STATES stall cycles; ERROR takes two cycles (ERR1 stall + ERR2).
// Backpressure: s_out_HREADY is held low during WAIT and ERR1; transfers are pipelined back-to-back otherwise.
module dmac_ahb_regif_mc
  import dmac_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                     s_HCLK,
  input  logic                     s_HRESETn,
  input  logic                     s_HSEL,
  input  logic [ADDR_W-1:0]        s_HADDR,
  input  logic [1:0]               s_HTRANS,
  input  logic                     s_HWRITE,
  input  logic [2:0]               s_HSIZE,
  input  logic [3:0]               s_HBURST,
  input  logic                     s_HREADY,
  input  logic [31:0]              s_HWDATA,
  output logic [31:0]              s_out_HRDATA,
  output logic                     s_out_HREADY,
  output logic [1:0]               s_out_HRESP,
  output logic [32*NUM_CH-1:0]     ch_src_addr,
  output logic [32*NUM_CH-1:0]     ch_dst_addr,
  output logic [CTRL_W*NUM_CH-1:0] ch_control,
  output logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic                     dmac_irq
);

  state_e      state_q;
  logic        hready_q;
  logic [1:0]  hresp_q;
  logic [1:0]  cnt_q;
  logic        write_q;
  dec_t        dec_q;
  logic        glb_en_q;

  logic        capture;
  dec_t        cap_dec;
  logic        cap_err;
  logic        wr_commit;
  logic        rd_active;
  logic [31:0] rdata_mux;

  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] ch_en_raw;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] ch_pend;
  logic [NUM_CH-1:0] int_status;
  logic [31:0]       ch_rdata [NUM_CH];

  // Burst type and SEQ/NONSEQ distinction carry no meaning here: every beat decodes on its own
  logic unused_bits;
  assign unused_bits = ^{s_HBURST, s_HTRANS[0]};

  // Map a byte address onto a global register or a channel window slot
  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t              d;
    logic [ADDR_W-1:0] rel;
    logic [ADDR_W-1:0] idx;
    d         = '0;
    rel       = a - ADDR_W'(CH_BASE_ADDR);
    idx       = rel >> CH_STRIDE_LOG2;
    d.glb_cfg = (a == ADDR_W'(GLB_CFG_ADDR));
    d.glb_int = (a == ADDR_W'(INT_STAT_ADDR));
    d.off     = rel[4:0];
    d.ch      = idx[2:0];
    d.ch_hit  = (a >= ADDR_W'(CH_BASE_ADDR)) && (idx < ADDR_W'(NUM_CH)) && off_valid(rel[4:0]);
    return d;
  endfunction

  assign capture   = s_HSEL && s_HREADY && s_HTRANS[1];
  assign cap_dec   = decode(s_HADDR);
  assign cap_err   = !(cap_dec.glb_cfg || cap_dec.glb_int || cap_dec.ch_hit) || (s_HSIZE != 3'b010);
  assign wr_commit = (state_q == ST_DATA) && write_q;
  assign rd_active = (state_q == ST_DATA) && !write_q;

  // Transfer FSM with registered HREADYOUT/HRESP; a capture in any ready cycle restarts it
  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      dec_q    <= '0;
    end else if (capture) begin
      write_q <= s_HWRITE;
      dec_q   <= cap_dec;
      if (cap_err) begin
        state_q  <= ST_ERR1;
        hready_q <= 1'b0;
        hresp_q  <= HRESP_ERROR;
      end else if (WAIT_STATES > 0) begin
        state_q  <= ST_WAIT;
        hready_q <= 1'b0;
        hresp_q  <= HRESP_OKAY;
        cnt_q    <= 2'(WAIT_STATES - 1);
      end else begin
        state_q  <= ST_DATA;
        hready_q <= 1'b1;
        hresp_q  <= HRESP_OKAY;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q  <= ST_DATA;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Global enable register; IntStatus is read-only so writes to it are accepted and dropped
  always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
    if (!s_HRESETn) begin
      glb_en_q <= 1'b0;
    end else if (wr_commit && dec_q.glb_cfg) begin
      glb_en_q <= s_HWDATA[0];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr[i] = wr_commit && dec_q.ch_hit && (dec_q.ch == 3'(i));

    dmac_ch_regs u_ch_regs (
      .clk_i      (s_HCLK),
      .rst_ni     (s_HRESETn),
      .wr_en_i    (ch_wr[i]),
      .offset_i   (dec_q.off),
      .wdata_i    (s_HWDATA),
      .ch_done_i  (ch_done[i]),
      .src_addr_o (ch_src_addr[32*i +: 32]),
      .dst_addr_o (ch_dst_addr[32*i +: 32]),
      .control_o  (ch_control[CTRL_W*i +: CTRL_W]),
      .en_o       (ch_en_raw[i]),
      .mask_o     (ch_mask[i]),
      .pend_o     (ch_pend[i]),
      .rdata_o    (ch_rdata[i])
    );
  end

  assign int_status = ch_pend & ~ch_mask;
  assign ch_enable  = ch_en_raw & {NUM_CH{glb_en_q}};
  assign dmac_irq   = |int_status;

  // Read data only during a read data phase; zero in every other cycle
  always_comb begin
    rdata_mux = '0;
    if (rd_active) begin
      if (dec_q.glb_cfg) begin
        rdata_mux = {31'b0, glb_en_q};
      end else if (dec_q.glb_int) begin
        rdata_mux = 32'(int_status);
      end else if (dec_q.ch_hit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (dec_q.ch == 3'(i)) rdata_mux = ch_rdata[i];
        end
      end
    end
  end

  assign s_out_HRDATA = rdata_mux;
  assign s_out_HREADY = hready_q;
  assign s_out_HRESP  = hresp_q;

endmodule

// File: tb/tb_dmac_ahb_regif_mc.sv
// Scoreboard bench for dmac_ahb_regif_mc: one zero-wait and one two-wait-state instance.
// Stimulus pushes expected bus responses; a negedge monitor pops and compares each completed data phase.
// Sideband outputs (channel fields, irq, reset values) are compared directly.
module tb_dmac_ahb_regif_mc;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel, sel_w;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hburst;
  logic [31:0] hwdata;
  logic [3:0]  ch_done;

  logic        hsel0, hsel_w;
  logic [31:0] rdata0, rdata_w;
  logic        hready0, hready_w;
  logic [1:0]  hresp0, hresp_w;
  logic [127:0] src0, src_w, dst0, dst_w;
  logic [59:0] ctrl0, ctrl_w;
  logic [3:0]  en0, en_w;
  logic        irq0, irq_w;

  logic        mon_hready;
  logic [1:0]  mon_hresp;
  logic [31:0] mon_rdata;

  always #5 clk = ~clk;

  assign hsel0      = hsel && !sel_w;
  assign hsel_w     = hsel && sel_w;
  assign mon_hready = sel_w ? hready_w : hready0;
  assign mon_hresp  = sel_w ? hresp_w  : hresp0;
  assign mon_rdata  = sel_w ? rdata_w  : rdata0;

  dmac_ahb_regif_mc #(.NUM_CH(4), .ADDR_W(12), .WAIT_STATES(0)) dut (
    .s_HCLK(clk), .s_HRESETn(rst_n), .s_HSEL(hsel0), .s_HADDR(haddr), .s_HTRANS(htrans),
    .s_HWRITE(hwrite), .s_HSIZE(hsize), .s_HBURST(hburst), .s_HREADY(hready0), .s_HWDATA(hwdata),
    .s_out_HRDATA(rdata0), .s_out_HREADY(hready0), .s_out_HRESP(hresp0),
    .ch_src_addr(src0), .ch_dst_addr(dst0), .ch_control(ctrl0), .ch_enable(en0),
    .ch_done(ch_done), .dmac_irq(irq0));

  dmac_ahb_regif_mc #(.NUM_CH(4), .ADDR_W(12), .WAIT_STATES(2)) dut_w (
    .s_HCLK(clk), .s_HRESETn(rst_n), .s_HSEL(hsel_w), .s_HADDR(haddr), .s_HTRANS(htrans),
    .s_HWRITE(hwrite), .s_HSIZE(hsize), .s_HBURST(hburst), .s_HREADY(hready_w), .s_HWDATA(hwdata),
    .s_out_HRDATA(rdata_w), .s_out_HREADY(hready_w), .s_out_HRESP(hresp_w),
    .ch_src_addr(src_w), .ch_dst_addr(dst_w), .ch_control(ctrl_w), .ch_enable(en_w),
    .ch_done(ch_done), .dmac_irq(irq_w));

  typedef struct {
    int          id;
    logic        is_read;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   xfer_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Wait for a cycle where the selected slave is ready, then step past that edge
  task automatic wait_rdy();
    int   n;
    logic r;
    n = 0;
    do begin
      @(negedge clk);
      r = mon_hready;
      n++;
    end while (!r && n < 40);
    if (!r) chk("hready_timeout", 32'(r), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Issue one address phase; its data phase runs while the next call presents its address
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [2:0] sz,
                      input logic [1:0] resp, input logic [31:0] rexp, input bit push);
    exp_t e;
    if (push) begin
      e.id      = xfer_id;
      e.is_read = !w;
      e.rdata   = rexp;
      e.resp    = resp;
      e.waits   = (resp == HRESP_ERROR) ? 1 : (sel_w ? 2 : 0);
      sb_q.push_back(e);
    end
    xfer_id++;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    wait_rdy();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = w ? d : 32'h0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 3'b010, HRESP_OKAY, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    xfer(1'b0, a, 32'h0, 3'b010, HRESP_OKAY, e, 1'b1);
  endtask

  task automatic bad(input logic w, input logic [11:0] a, input logic [2:0] sz);
    xfer(w, a, 32'hA5A5_A5A5, sz, HRESP_ERROR, 32'h0, 1'b1);
  endtask

  task automatic idle();
    wait_rdy();
  endtask

  task automatic pulse(input logic [3:0] m);
    ch_done = m;
    @(posedge clk);
    #1;
    ch_done = 4'b0;
  endtask

  // Monitor: tracks data phases of the selected slave and scores each completed one
  logic dphase = 1'b0;
  int   lowcnt = 0;
  logic [1:0] low_resp = 2'b00;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      dphase = 1'b0;
      lowcnt = 0;
    end else begin
      if (dphase && !mon_hready) begin
        lowcnt++;
        low_resp = mon_hresp;
      end else begin
        if (dphase) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_xfer", 32'(sb_q.size()), 32'd1);
          end else begin
            mon_e = sb_q.pop_front();
            chk($sformatf("xfer%0d_resp", mon_e.id), 32'(mon_hresp), 32'(mon_e.resp));
            chk($sformatf("xfer%0d_waits", mon_e.id), 32'(lowcnt), 32'(mon_e.waits));
            if (lowcnt > 0)
              chk($sformatf("xfer%0d_stall_resp", mon_e.id), 32'(low_resp), 32'(mon_e.resp));
            if (mon_e.is_read)
              chk($sformatf("xfer%0d_rdata", mon_e.id), mon_rdata, mon_e.rdata);
          end
        end
        dphase = hsel && htrans[1] && mon_hready;
        lowcnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    hsel = 1'b0; sel_w = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 4'b0011; hwdata = '0; ch_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hready", 32'(hready0), 32'd1);
    chk("rst_hresp", 32'(hresp0), 32'(HRESP_OKAY));
    chk("rst_hrdata", rdata0, 32'h0);
    chk("rst_irq", 32'(irq0), 32'd0);
    chk("rst_ch_enable", 32'(en0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ch1 SrcAddr write/read back-to-back; enable gating
    wr(12'h120, 32'h1234_5678);
    rd(12'h120, 32'h1234_5678);
    idle();
    chk("ch1_src_port", src0[63:32], 32'h1234_5678);
    wr(12'h130, 32'h1);
    wr(12'h030, 32'h1);
    idle();
    chk("ch_enable_on", 32'(en0), 32'h2);
    wr(12'h030, 32'h0);
    idle();
    chk("ch_enable_gated", 32'(en0), 32'h0);
    rd(12'h130, 32'h1);
    rd(12'h030, 32'h0);

    // 2: unmapped address, channel index past NUM_CH, hole offset
    bad(1'b1, 12'h0F0, 3'b010);
    rd(12'h120, 32'h1234_5678);
    bad(1'b0, 12'h180, 3'b010);
    bad(1'b0, 12'h108, 3'b010);
    rd(12'h030, 32'h0);

    // 3: Control width and non-word size
    wr(12'h10C, 32'hFFFF_FFFF);
    rd(12'h10C, 32'h0000_7FFF);
    bad(1'b1, 12'h100, 3'b000);
    rd(12'h100, 32'h0);
    idle();
    chk("ch0_control_port", 32'(ctrl0[14:0]), 32'h7FFF);

    // 4: pend set, set-wins over W1C, W1C clear, mask
    pulse(4'b0100);
    chk("irq_after_done", 32'(irq0), 32'd1);
    rd(12'h034, 32'h4);
    rd(12'h150, 32'h4);
    wr(12'h150, 32'h4);
    pulse(4'b0100);
    chk("irq_set_wins", 32'(irq0), 32'd1);
    rd(12'h034, 32'h4);
    wr(12'h150, 32'h4);
    idle();
    chk("irq_after_w1c", 32'(irq0), 32'd0);
    rd(12'h034, 32'h0);
    wr(12'h110, 32'h2);
    idle();
    pulse(4'b0001);
    chk("irq_masked", 32'(irq0), 32'd0);
    rd(12'h110, 32'h6);
    rd(12'h034, 32'h0);
    idle();

    // 5: two wait states; back-to-back write then read
    sel_w = 1'b1;
    rd(12'h030, 32'h0);
    wr(12'h104, 32'hCAFE_BABE);
    rd(12'h104, 32'hCAFE_BABE);
    bad(1'b0, 12'h0F0, 3'b010);
    idle();
    chk("w_ch0_dst_port", dst_w[31:0], 32'hCAFE_BABE);

    // 6: reset during the WAIT phase of a write
    xfer(1'b1, 12'h164, 32'h5555_5555, 3'b010, HRESP_OKAY, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hready", 32'(hready_w), 32'd1);
    chk("midrst_hresp", 32'(hresp_w), 32'(HRESP_OKAY));
    chk("midrst_hrdata", rdata_w, 32'h0);
    chk("midrst_irq", 32'(irq_w), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(12'h164, 32'h0);
    rd(12'h104, 32'h0);
    idle();
    chk("w_ch3_dst_discarded", dst_w[127:96], 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
